// File: rtl/rr_arbiter_n.sv
// Registered round-robin arbiter: one grant held until the owner releases it, then the search pointer rotates.
// Optional hold-time limit with TIMEOUT_ERR pulse is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_n #(
   parameter int N       = 8,
   parameter int ID_W    = 3,
   parameter int TIMEOUT = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N-1:0]    REQ,
   input  logic            DONE,
   output logic [N-1:0]    GNT,
   output logic [ID_W-1:0] GNT_ID,
   output logic            GNT_VLD
`ifdef ARB_TIMEOUT_EN
   ,
   output logic            TIMEOUT_ERR
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] ptr, ptr_nxt;
   logic [ID_W-1:0] gnt_id_nxt;
   logic [N-1:0]    gnt_nxt;
   logic [ID_W-1:0] rot_ptr;
   logic [ID_W-1:0] search_start;
   logic [ID_W-1:0] winner;
   logic            found;
   logic            owner_release;
   logic            forced;
   logic            release_now;

`ifdef ARB_TIMEOUT_EN
   logic [7:0]      hold_cnt, hold_cnt_nxt;
   logic            err_nxt;
`endif

   if (N < 2 || N > 32 || (1 << ID_W) < N || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
      $error("rr_arbiter_n: illegal parameter combination");
   end

   assign rot_ptr       = (GNT_ID == ID_W'(N - 1)) ? '0 : GNT_ID + 1'b1;
   assign owner_release = DONE || !REQ[GNT_ID];
`ifdef ARB_TIMEOUT_EN
   // A natural release in the limit cycle wins, so the error only fires when nothing else released.
   assign forced        = (state == BUSY) && !owner_release && (hold_cnt == 8'(TIMEOUT - 1));
`else
   assign forced        = 1'b0;
`endif
   assign release_now   = owner_release || forced;
   assign search_start  = (state == BUSY) ? rot_ptr : ptr;
   assign GNT_VLD       = |GNT;

   // Circular scan from search_start; wraps explicitly so non-power-of-2 N never indexes past N-1.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(search_start) + k;
         if (idx >= N) idx = idx - N;
         if (!found && REQ[ID_W'(idx)]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      gnt_nxt      = GNT;
      gnt_id_nxt   = GNT_ID;
      ptr_nxt      = ptr;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_nxt = hold_cnt;
      err_nxt      = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               gnt_nxt         = '0;
               gnt_nxt[winner] = 1'b1;
               gnt_id_nxt      = winner;
               state_nxt       = BUSY;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_nxt    = 8'd0;
`endif
            end
         end
         BUSY: begin
            if (release_now) begin
               ptr_nxt = rot_ptr;
`ifdef ARB_TIMEOUT_EN
               err_nxt      = forced;
               hold_cnt_nxt = 8'd0;
`endif
               // Back-to-back handover in the same edge avoids an idle bubble between owners.
               if (found) begin
                  gnt_nxt         = '0;
                  gnt_nxt[winner] = 1'b1;
                  gnt_id_nxt      = winner;
               end else begin
                  gnt_nxt    = '0;
                  gnt_id_nxt = '0;
                  state_nxt  = IDLE;
               end
            end else begin
`ifdef ARB_TIMEOUT_EN
               hold_cnt_nxt = hold_cnt + 8'd1;
`endif
            end
         end
         default: begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            gnt_id_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         GNT         <= '0;
         GNT_ID      <= '0;
         ptr         <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt    <= 8'd0;
         TIMEOUT_ERR <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         GNT         <= gnt_nxt;
         GNT_ID      <= gnt_id_nxt;
         ptr         <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
         hold_cnt    <= hold_cnt_nxt;
         TIMEOUT_ERR <= err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: an 8-requester and a 5-requester instance driven by directed vectors.
// With ARB_TIMEOUT_EN defined the 5-requester instance (TIMEOUT=4) also exercises forced release.
module tb_rr_arbiter_n;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] id;
      logic       vld;
      logic       err;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] req8 = '0;
   logic       done8 = 1'b0;
   logic [7:0] gnt8;
   logic [2:0] id8;
   logic       vld8;
   logic       err8;
   logic [4:0] req5 = '0;
   logic       done5 = 1'b0;
   logic [4:0] gnt5;
   logic [2:0] id5;
   logic       vld5;
   logic       err5;

   exp_t  q8[$];
   exp_t  q5[$];
   string n8[$];
   string n5[$];
   exp_t  e8, e5;
   string nm8, nm5;
   int    checks   = 0;
   int    failures = 0;

   always #5 CLK = ~CLK;

   rr_arbiter_n #(.N(8), .ID_W(3), .TIMEOUT(16)) dut8 (
      .CLK(CLK), .RST(RST), .REQ(req8), .DONE(done8),
      .GNT(gnt8), .GNT_ID(id8), .GNT_VLD(vld8)
`ifdef ARB_TIMEOUT_EN
      , .TIMEOUT_ERR(err8)
`endif
   );

   rr_arbiter_n #(.N(5), .ID_W(3), .TIMEOUT(4)) dut5 (
      .CLK(CLK), .RST(RST), .REQ(req5), .DONE(done5),
      .GNT(gnt5), .GNT_ID(id5), .GNT_VLD(vld5)
`ifdef ARB_TIMEOUT_EN
      , .TIMEOUT_ERR(err5)
`endif
   );

`ifndef ARB_TIMEOUT_EN
   assign err8 = 1'b0;
   assign err5 = 1'b0;
`endif

   // Drive one cycle of the 8-way instance and queue the response expected after the next edge.
   task automatic applyStimulus(input logic rst, input logic [7:0] req, input logic done,
                                input int exp_id, input logic exp_vld, input string name);
      exp_t e;
      @(negedge CLK);
      RST   = rst;
      req8  = req;
      done8 = done;
      e.id  = 3'(exp_id);
      e.vld = exp_vld;
      e.gnt = exp_vld ? (8'd1 << exp_id) : 8'd0;
      e.err = 1'b0;
      q8.push_back(e);
      n8.push_back(name);
   endtask

   task automatic applyStimulus5(input logic [4:0] req, input logic done, input int exp_id,
                                 input logic exp_vld, input logic exp_err, input string name);
      exp_t e;
      @(negedge CLK);
      req5  = req;
      done5 = done;
      e.id  = 3'(exp_id);
      e.vld = exp_vld;
      e.gnt = exp_vld ? (8'd1 << exp_id) : 8'd0;
      e.err = exp_err;
      q5.push_back(e);
      n5.push_back(name);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act_gnt, input logic [2:0] act_id,
                              input logic act_vld, input logic act_err, input exp_t e);
      checks++;
      if (act_gnt !== e.gnt || act_id !== e.id || act_vld !== e.vld || act_err !== e.err) begin
         failures++;
         $display("[TB] FAIL %s: got gnt=%b id=%0d vld=%b err=%b, expected gnt=%b id=%0d vld=%b err=%b",
                  name, act_gnt, act_id, act_vld, act_err, e.gnt, e.id, e.vld, e.err);
      end
   endtask

   always @(posedge CLK) begin
      #1;
      if (q8.size() > 0) begin
         e8  = q8.pop_front();
         nm8 = n8.pop_front();
         checkOutput(nm8, gnt8, id8, vld8, err8, e8);
      end
   end

   always @(posedge CLK) begin
      #1;
      if (q5.size() > 0) begin
         e5  = q5.pop_front();
         nm5 = n5.pop_front();
         checkOutput(nm5, {3'b000, gnt5}, id5, vld5, err5, e5);
      end
   end

   initial begin
      applyStimulus(1'b1, 8'h00, 1'b0, 0, 1'b0, "reset");
      applyStimulus(1'b0, 8'h00, 1'b1, 0, 1'b0, "idle_done1");
      applyStimulus(1'b0, 8'h00, 1'b0, 0, 1'b0, "idle_quiet");
      applyStimulus(1'b0, 8'h00, 1'b1, 0, 1'b0, "idle_done2");

      applyStimulus(1'b0, 8'b1000_0100, 1'b0, 2, 1'b1, "first_grant");
      applyStimulus(1'b0, 8'b1000_0100, 1'b0, 2, 1'b1, "hold_a");
      applyStimulus(1'b0, 8'b1111_0111, 1'b0, 2, 1'b1, "hold_no_preempt");
      applyStimulus(1'b0, 8'b0000_0100, 1'b0, 2, 1'b1, "hold_c");
      applyStimulus(1'b0, 8'b1000_0100, 1'b0, 2, 1'b1, "hold_d");
      applyStimulus(1'b0, 8'b1000_0100, 1'b1, 7, 1'b1, "done_to_7");

      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 8'hFF, 1'b1, i % 8, 1'b1, $sformatf("wrap_%0d", i));

      applyStimulus(1'b0, 8'b0000_1000, 1'b1, 3, 1'b1, "grant_3");
      applyStimulus(1'b0, 8'b0000_1000, 1'b0, 3, 1'b1, "hold_3");
      applyStimulus(1'b0, 8'b0000_0010, 1'b0, 1, 1'b1, "drop_3_to_1");
      applyStimulus(1'b0, 8'b0000_0000, 1'b0, 0, 1'b0, "drop_all");
      applyStimulus(1'b0, 8'b0001_0100, 1'b0, 2, 1'b1, "idle_ptr2");
      applyStimulus(1'b0, 8'b0001_1000, 1'b1, 3, 1'b1, "done_and_drop");
      applyStimulus(1'b0, 8'b0010_0000, 1'b1, 5, 1'b1, "grant_5");
      applyStimulus(1'b1, 8'b0010_0001, 1'b0, 0, 1'b0, "reset_mid_grant");
      applyStimulus(1'b0, 8'b0010_0001, 1'b0, 0, 1'b1, "ptr_back_0");
      applyStimulus(1'b0, 8'b0010_0001, 1'b1, 5, 1'b1, "rotate_to_5");
      applyStimulus(1'b0, 8'b0000_0000, 1'b0, 0, 1'b0, "back_idle");

      applyStimulus5(5'b11111, 1'b1, 0, 1'b1, 1'b0, "n5_first");
      for (int i = 1; i <= 5; i++)
         applyStimulus5(5'b11111, 1'b1, i % 5, 1'b1, 1'b0, $sformatf("n5_wrap_%0d", i));
      applyStimulus5(5'b00000, 1'b0, 0, 1'b0, 1'b0, "n5_idle");

`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 4; i++)
         applyStimulus5(5'b00011, 1'b0, 1, 1'b1, 1'b0, $sformatf("to_hold_%0d", i));
      applyStimulus5(5'b00011, 1'b0, 0, 1'b1, 1'b1, "to_forced");
      for (int i = 0; i < 3; i++)
         applyStimulus5(5'b00011, 1'b0, 0, 1'b1, 1'b0, $sformatf("to_hold2_%0d", i));
      applyStimulus5(5'b00011, 1'b1, 1, 1'b1, 1'b0, "to_done_wins");
      applyStimulus5(5'b00000, 1'b0, 0, 1'b0, 1'b0, "to_idle");
`endif

      repeat (3) @(negedge CLK);
      checks++;
      if (q8.size() != 0 || q5.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", q8.size(), q5.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
